sync_down_counter: RTL

SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

---
 rtl/sync_down_counter.sv | 91 +++++++++
 1 files changed

// File: rtl/sync_down_counter.sv
// Loadable down counter with one-shot / periodic run control (IDLE -> RUN -> DONE).
// Define SYNC_DOWN_COUNTER_CASCADE_EN to add the borrow_out chaining output.
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
`ifdef SYNC_DOWN_COUNTER_CASCADE_EN
    ,
    output logic             borrow_out
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic             mode_l;

    // Floor at zero so a stray decrement request can never wrap the count.
    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            reload <= '0;
            mode_l <= 1'b0;
            tc     <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                reload <= load_val;
                q      <= load_val;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state  <= RUN;
                            mode_l <= mode;
                        end
                    end
                    RUN: begin
                        // stop outranks expiry, so an aborted run never pulses done/tc
                        if (stop) begin
                            state <= IDLE;
                        end else if (en) begin
                            if (q != '0) begin
                                q <= sat_dec(q);
                            end else if (mode_l) begin
                                q  <= reload;
                                tc <= 1'b1;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef SYNC_DOWN_COUNTER_CASCADE_EN
    assign borrow_out = busy & en & (q == '0);
`endif

endmodule
